// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stall/flush/forward/IRQ controls out.
interface pipeline_hazard_ctrl_if;
  logic [1:0] id_rs_a, id_rs_b;
  logic       id_uses_a, id_uses_b;
  logic [1:0] ex_rs_a, ex_rs_b;
  logic       ex_uses_a, ex_uses_b;
  logic       ex_reg_write, ex_mem_read;
  logic [1:0] ex_reg_dist;
  logic       mem_reg_write;
  logic [1:0] mem_reg_dist;
  logic       wb_reg_write;
  logic [1:0] wb_reg_dist;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       irq;

  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       irq_epc_capture;
  logic       pc_sel_vector, irq_ack;
  logic       mem_timeout;

  // Controller side: drives the control outputs.
  modport master (
    input  id_rs_a, id_rs_b, id_uses_a, id_uses_b,
    input  ex_rs_a, ex_rs_b, ex_uses_a, ex_uses_b,
    input  ex_reg_write, ex_mem_read, ex_reg_dist,
    input  mem_reg_write, mem_reg_dist, wb_reg_write, wb_reg_dist,
    input  ex_branch_taken, mem_busy, irq,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_flush, id_ex_flush, mem_wb_flush,
    output fwd_a, fwd_b, irq_epc_capture, pc_sel_vector, irq_ack, mem_timeout
  );

  // Pipeline side: supplies status, consumes controls.
  modport slave (
    output id_rs_a, id_rs_b, id_uses_a, id_uses_b,
    output ex_rs_a, ex_rs_b, ex_uses_a, ex_uses_b,
    output ex_reg_write, ex_mem_read, ex_reg_dist,
    output mem_reg_write, mem_reg_dist, wb_reg_write, wb_reg_dist,
    output ex_branch_taken, mem_busy, irq,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input  if_id_flush, id_ex_flush, mem_wb_flush,
    input  fwd_a, fwd_b, irq_epc_capture, pc_sel_vector, irq_ack, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline. State is registered;
// control outputs are combinational from state and the current inputs.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 15
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.master hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, IRQ_DRAIN, IRQ_VEC} state_e;

  state_e     state_q, state_d;
  logic [2:0] drain_q, drain_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       timeout_hit;

  logic       load_use;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_flush;
  logic       epc_cap, vec_sel, ack;
  logic [1:0] fwd_a, fwd_b;

  // EX/MEM result wins over MEM/WB since it is the younger write.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [1:0] rs,
                                         input logic mwe, input logic [1:0] md,
                                         input logic wwe, input logic [1:0] wd);
    if (uses && mwe && md == rs)      return 2'b01;
    else if (uses && wwe && wd == rs) return 2'b10;
    else                              return 2'b00;
  endfunction

  assign load_use = hz.ex_mem_read && hz.ex_reg_write &&
                    ((hz.id_uses_a && hz.id_rs_a == hz.ex_reg_dist) ||
                     (hz.id_uses_b && hz.id_rs_b == hz.ex_reg_dist));

  // Memory wait counter and sticky timeout; the flag is visible in the cycle the count hits.
  always_comb begin
    wait_d      = '0;
    if (hz.mem_busy) wait_d = (wait_q == 8'hff) ? 8'hff : 8'(wait_q + 8'd1);
    timeout_hit = hz.mem_busy && (wait_d >= 8'(MEM_TIMEOUT));
    timeout_d   = timeout_q || timeout_hit;
  end

  // Next state and control outputs; freeze overrides everything else.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    epc_cap      = 1'b0;
    vec_sel      = 1'b0;
    ack          = 1'b0;
    if (hz.mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
      if (state_q == RUN) state_d = MEM_WAIT;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          // The live pipe resumes on the release cycle, so hazards are honoured
          // there too; only IRQ entry is restricted to RUN proper.
          state_d = RUN;
          if (hz.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (state_q == RUN && hz.irq) begin
            if_id_flush = 1'b1;
            pc_stall    = 1'b1;
            epc_cap     = 1'b1;
            state_d     = IRQ_DRAIN;
            drain_d     = 3'(DRAIN_CYCLES);
          end
        end
        IRQ_DRAIN: begin
          pc_stall    = 1'b1;
          id_ex_flush = 1'b1;
          drain_d     = drain_q - 3'd1;
          if (drain_q <= 3'd1) begin
            drain_d = '0;
            state_d = IRQ_VEC;
          end
        end
        IRQ_VEC: begin
          vec_sel = 1'b1;
          ack     = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Operand forwarding selects, independent of state.
  always_comb begin
    fwd_a = fwd_sel(hz.ex_uses_a, hz.ex_rs_a, hz.mem_reg_write, hz.mem_reg_dist,
                    hz.wb_reg_write, hz.wb_reg_dist);
    fwd_b = fwd_sel(hz.ex_uses_b, hz.ex_rs_b, hz.mem_reg_write, hz.mem_reg_dist,
                    hz.wb_reg_write, hz.wb_reg_dist);
  end

  // State registers; reset abandons any pending drain or vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      drain_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // All outputs are forced low while reset is held.
  assign hz.pc_stall        = !rst && pc_stall;
  assign hz.if_id_stall     = !rst && if_id_stall;
  assign hz.id_ex_stall     = !rst && id_ex_stall;
  assign hz.ex_mem_stall    = !rst && ex_mem_stall;
  assign hz.if_id_flush     = !rst && if_id_flush;
  assign hz.id_ex_flush     = !rst && id_ex_flush;
  assign hz.mem_wb_flush    = !rst && mem_wb_flush;
  assign hz.irq_epc_capture = !rst && epc_cap;
  assign hz.pc_sel_vector   = !rst && vec_sel;
  assign hz.irq_ack         = !rst && ack;
  assign hz.mem_timeout     = !rst && (timeout_q || timeout_hit);
  assign hz.fwd_a           = rst ? 2'b00 : fwd_a;
  assign hz.fwd_b           = rst ? 2'b00 : fwd_b;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: expected output vectors are queued as stimulus is applied
// and compared against the DUT outputs once they settle.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  // Output vector layout:
  // [14]pc_stall [13]if_id_stall [12]id_ex_stall [11]ex_mem_stall
  // [10]if_id_flush [9]id_ex_flush [8]mem_wb_flush [7:6]fwd_a [5:4]fwd_b
  // [3]irq_epc_capture [2]pc_sel_vector [1]irq_ack [0]mem_timeout
  localparam logic [14:0] O_PC  = 15'h4000;
  localparam logic [14:0] O_IFS = 15'h2000;
  localparam logic [14:0] O_IFF = 15'h0400;
  localparam logic [14:0] O_IDF = 15'h0200;
  localparam logic [14:0] O_FRZ = 15'h7900;
  localparam logic [14:0] A01   = 15'h0040;
  localparam logic [14:0] A10   = 15'h0080;
  localparam logic [14:0] B01   = 15'h0010;
  localparam logic [14:0] B10   = 15'h0020;
  localparam logic [14:0] O_EPC = 15'h0008;
  localparam logic [14:0] O_VEC = 15'h0004;
  localparam logic [14:0] O_ACK = 15'h0002;
  localparam logic [14:0] O_TO  = 15'h0001;
  localparam logic [14:0] LU    = O_PC | O_IFS | O_IDF;
  localparam logic [14:0] ENTRY = O_PC | O_IFF | O_EPC;
  localparam logic [14:0] DRAIN = O_PC | O_IDF;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [14:0] observed();
    return {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush,
            bus.fwd_a, bus.fwd_b, bus.irq_epc_capture, bus.pc_sel_vector,
            bus.irq_ack, bus.mem_timeout};
  endfunction

  task automatic expect_out(input string tag, input logic [14:0] e);
    logic [14:0] o, want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    o    = observed();
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (o === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, want);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs_a = 0; bus.id_rs_b = 0; bus.id_uses_a = 0; bus.id_uses_b = 0;
    bus.ex_rs_a = 0; bus.ex_rs_b = 0; bus.ex_uses_a = 0; bus.ex_uses_b = 0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_reg_dist = 0;
    bus.mem_reg_write = 0; bus.mem_reg_dist = 0;
    bus.wb_reg_write = 0; bus.wb_reg_dist = 0;
    bus.ex_branch_taken = 0; bus.mem_busy = 0; bus.irq = 0;
  endtask

  task automatic set_load_use();
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_reg_dist = 2;
    bus.id_rs_a = 2; bus.id_uses_a = 1;
  endtask

  initial begin
    // Reset with busy/irq/load-use active: everything low.
    rst = 1'b1;
    idle();
    set_load_use();
    bus.mem_busy = 1; bus.irq = 1;
    expect_out("reset_outputs", '0);
    next();
    expect_out("reset_held", '0);
    idle();
    rst = 1'b0;
    expect_out("post_reset_idle", '0);
    next();

    // Load-use on rs_a, held for two cycles (no state change), then cleared.
    set_load_use();
    expect_out("load_use_a", LU);
    next();
    expect_out("load_use_again", LU);
    next();
    bus.ex_mem_read = 0;
    expect_out("load_use_dropped", '0);
    next();
    idle();
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_reg_dist = 3;
    bus.id_rs_b = 3; bus.id_uses_b = 1; bus.id_rs_a = 3;
    expect_out("load_use_b", LU);
    next();
    idle();

    // Forwarding priority.
    bus.ex_rs_b = 1; bus.ex_uses_b = 1; bus.mem_reg_write = 1; bus.mem_reg_dist = 1;
    bus.wb_reg_write = 1; bus.wb_reg_dist = 1;
    expect_out("fwd_b_exmem", B01);
    bus.mem_reg_write = 0;
    expect_out("fwd_b_memwb", B10);
    bus.ex_uses_b = 0;
    expect_out("fwd_b_none", '0);
    bus.ex_uses_a = 1; bus.ex_rs_a = 1; bus.mem_reg_write = 1; bus.mem_reg_dist = 2;
    expect_out("fwd_a_dist_mismatch", A10);
    next();
    idle();

    // Branch beats load-use and irq; irq entry on the next clean cycle.
    set_load_use();
    bus.ex_branch_taken = 1; bus.irq = 1;
    expect_out("branch_priority", O_IFF | O_IDF);
    next();
    idle();
    bus.irq = 1;
    expect_out("irq_entry", ENTRY);
    next();
    bus.ex_uses_a = 1; bus.ex_rs_a = 3; bus.wb_reg_write = 1; bus.wb_reg_dist = 3;
    bus.ex_branch_taken = 1;
    expect_out("drain1_fwd_branch_ignored", DRAIN | A10);
    next();
    idle();
    bus.irq = 1;
    expect_out("drain2", DRAIN);
    next();
    expect_out("drain3", DRAIN);
    next();
    expect_out("irq_vec", O_VEC | O_ACK);
    next();
    bus.irq = 0;
    expect_out("irq_back_to_run", '0);
    next();

    // IRQ with a two-cycle freeze inside the drain.
    bus.irq = 1;
    expect_out("frz_irq_entry", ENTRY);
    next();
    expect_out("frz_drain1", DRAIN);
    next();
    bus.mem_busy = 1;
    expect_out("frz_freeze1", O_FRZ);
    next();
    expect_out("frz_freeze2", O_FRZ);
    next();
    bus.mem_busy = 0;
    expect_out("frz_drain2", DRAIN);
    next();
    expect_out("frz_drain3", DRAIN);
    next();
    expect_out("frz_vec", O_VEC | O_ACK);
    next();
    bus.irq = 0;
    expect_out("frz_run", '0);
    next();

    // Memory timeout after 15 consecutive busy cycles; sticky afterwards.
    bus.mem_busy = 1;
    for (int i = 1; i <= 15; i++) begin
      expect_out($sformatf("busy_cycle_%0d", i), (i == 15) ? (O_FRZ | O_TO) : O_FRZ);
      next();
    end
    bus.mem_busy = 0;
    expect_out("timeout_sticky", O_TO);
    next();
    expect_out("timeout_sticky2", O_TO);
    next();

    // Reset in the middle of a drain abandons it.
    bus.irq = 1;
    expect_out("rst_irq_entry", ENTRY | O_TO);
    next();
    expect_out("rst_drain1", DRAIN | O_TO);
    next();
    rst = 1'b1;
    expect_out("rst_mid_drain", '0);
    next();
    rst = 1'b0;
    bus.irq = 0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("rst_no_vector_%0d", i), '0);
      next();
    end
    set_load_use();
    expect_out("rst_back_in_run", LU);
    next();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage 8-bit pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, taken-branch redirects and multi-cycle memory waits, and sequences interrupt entry by draining the pipe.
- Drives operand-forwarding selects for EX and the stall/flush inputs of every pipeline register.
- State is registered; all stall/flush/forward outputs are combinational from state plus inputs.

Parameters:
DRAIN_CYCLES, 3, bubble cycles issued after IRQ entry so EX/MEM/WB retire (1..7).
MEM_TIMEOUT, 15, consecutive mem_busy cycles before the timeout flag sets (1..255).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs_a, id_rs_b  in  2 each  source registers of the instruction in ID
id_uses_a, id_uses_b  in  1 each  ID instruction reads rs_a / rs_b
ex_rs_a, ex_rs_b  in  2 each  source registers of the instruction in EX
ex_uses_a, ex_uses_b  in  1 each  EX instruction reads rs_a / rs_b
ex_reg_write, ex_mem_read  in  1 each  EX instruction writes a register / is a load
ex_reg_dist  in  2  EX destination register
mem_reg_write  in  1  MEM-stage write enable
mem_reg_dist  in  2  MEM-stage destination register
wb_reg_write  in  1  WB-stage write enable
wb_reg_dist  in  2  WB-stage destination register
ex_branch_taken  in  1  branch resolved taken in EX
mem_busy  in  1  data memory not ready this cycle
irq  in  1  level interrupt request; source holds it until irq_ack
pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register
if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble into the register
fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 EX/MEM, 10 MEM/WB
irq_epc_capture  out  1  PC unit saves the ID-stage PC
pc_sel_vector, irq_ack  out  1 each  load the interrupt vector; acknowledge the source
mem_timeout  out  1  sticky error flag

Behaviour:
Reset:
- On rst: state RUN, drain counter 0, wait counter 0, mem_timeout 0.
- While rst is high, every output is 0.

States: RUN, MEM_WAIT, IRQ_DRAIN, IRQ_VEC.

Freeze (any state, when mem_busy=1):
- pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1; mem_wb_flush is 1.
- All other stall/flush and IRQ outputs are 0.
- Freeze has priority over every other rule.
- RUN moves to MEM_WAIT; MEM_WAIT returns to RUN on the first cycle mem_busy=0.
- IRQ_DRAIN and IRQ_VEC stay in their state, with the drain counter held.

Wait counter:
- Increments each mem_busy cycle, saturating at 255, and clears when mem_busy=0.
- mem_timeout sets when the counter reaches MEM_TIMEOUT and clears only on rst.

Branch (RUN, no freeze, ex_branch_taken=1):
- if_id_flush=1 and id_ex_flush=1.
- Any load-use stall is suppressed, and irq is not taken this cycle.

Load-use (RUN, no freeze, no branch):
- Condition: ex_mem_read and ex_reg_write, and either (id_uses_a and id_rs_a==ex_reg_dist) or (id_uses_b and id_rs_b==ex_reg_dist).
- Response: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly that cycle. No state change.

IRQ entry (RUN, no freeze, no branch, no load-use, irq=1):
- if_id_flush=1, pc_stall=1, irq_epc_capture=1 (single pulse).
- Go to IRQ_DRAIN with drain counter = DRAIN_CYCLES.

IRQ_DRAIN:
- pc_stall=1 and id_ex_flush=1.
- Counter decrements on each non-freeze cycle; at 1→0, go to IRQ_VEC.
- ex_branch_taken is ignored; the pipe holds no younger branch.

IRQ_VEC:
- pc_sel_vector=1 and irq_ack=1 for exactly one non-freeze cycle, then RUN.
- irq is ignored outside RUN and is re-sampled only from RUN.

Forwarding (every state, combinational):
- fwd_a=01 if ex_uses_a, mem_reg_write and mem_reg_dist==ex_rs_a.
- Otherwise fwd_a=10 if ex_uses_a, wb_reg_write and wb_reg_dist==ex_rs_a.
- Otherwise fwd_a=00. fwd_b is identical using ex_rs_b/ex_uses_b.
- EX/MEM has priority over MEM/WB.

Reset mid-operation:
- rst in any state returns immediately to RUN with all outputs 0.
- A pending drain or vector is abandoned.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_reg_dist=2, id_rs_a=2, id_uses_a=1 → pc_stall=1, if_id_stall=1, id_ex_flush=1 for one cycle; drop ex_mem_read → all 0.
- Branch beats load-use and irq: the load-use condition above plus ex_branch_taken=1 and irq=1 → if_id_flush=1, id_ex_flush=1, pc_stall=0, irq_epc_capture=0; irq taken the next clean cycle.
- Forward priority: ex_rs_b=1, ex_uses_b=1, mem_reg_write=1, mem_reg_dist=1, wb_reg_write=1, wb_reg_dist=1 → fwd_b=01; clear mem_reg_write → fwd_b=10; clear ex_uses_b → fwd_b=00.
- IRQ sequence with DRAIN_CYCLES=3: irq=1 in clean RUN → irq_epc_capture on cycle 0, then 3 cycles of pc_stall+id_ex_flush, then 1 cycle of irq_ack+pc_sel_vector, then RUN.
- IRQ with freeze: mem_busy=1 for 2 cycles during the second drain cycle → drain extends to 5 cycles, irq_ack still a single cycle.
- Timeout and reset: mem_busy held 15 cycles → mem_timeout=1 from the 15th cycle and stays set after mem_busy drops; assert rst during IRQ_DRAIN → all outputs 0, mem_timeout 0, RUN afterwards.
